prog_mem_loader: RTL

- Writer side of the CPU program memory, which the CPU only reads via its MAR-addressed instruction fetch.
- Accepts a framed byte stream over a valid/ready handshake and assembles 14-bit instruction words.
- Writes the words sequentially from address 0 into the 2048x14 program RAM.
- Holds the CPU in reset while loading, then releases it so execution restarts at PC 0.

---
 rtl/pic_pkg.sv | 19 +
 rtl/prog_mem_loader_if.sv | 20 ++
 rtl/loader_checksum.sv | 20 ++
 rtl/prog_mem_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared program-memory geometry and loader state encoding.
// The CPU fetch path and the program RAM use the same width constants.
package pic_pkg;
  localparam int PM_ADDR_W = 11;
  localparam int PM_DATA_W = 14;
  localparam int MAX_WORDS = 2048;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_W_LO,
    S_W_HI,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;
endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte stream in (valid/ready) and program-memory write port out.
// slave = loader side, master = byte source / memory side.
interface prog_mem_loader_if;
  logic                         rx_valid;
  logic [7:0]                   rx_data;
  logic                         rx_ready;
  logic                         pm_we;
  logic [pic_pkg::PM_ADDR_W-1:0] pm_addr;
  logic [pic_pkg::PM_DATA_W-1:0] pm_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, pm_we, pm_addr, pm_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, pm_we, pm_addr, pm_wdata
  );
endinterface

// File: rtl/loader_checksum.sv
// 8-bit modular byte accumulator. zero reports whether the running sum
// plus the byte currently on din is 0, so the final byte can be judged in-cycle.
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic       zero
);
  logic [7:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= 8'h00;
    else if (clr) acc <= 8'h00;
    else if (add) acc <= acc + din;
  end

  assign zero = ((acc + din) == 8'h00);
endmodule

// File: rtl/prog_mem_loader.sv
// Framed byte-stream loader for the 2048x14 program RAM; holds the CPU in reset
// while loading. Define PROG_LOADER_CSUM_EN to require a trailing checksum byte.
module prog_mem_loader
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  prog_mem_loader_if.slave   bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);
  loader_state_t          state_q, state_d;
  logic [15:0]            len_q;
  logic [15:0]            cnt_q;
  logic [7:0]             lo_q;
  logic [PM_ADDR_W-1:0]   addr_q;
  logic [PM_DATA_W-1:0]   wdata_q;
  logic                   done_q;
  logic                   rdy;
  logic                   xfer;
  logic                   start_ok;
  logic [15:0]            len_n;
  logic                   len_bad;
  logic                   last_word;
  logic                   csum_zero;

  assign xfer      = bus.rx_valid & rdy;
  assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign len_n     = {bus.rx_data, len_q[7:0]};
  assign len_bad   = (len_n == 16'd0) || (len_n > 16'(MAX_WORDS));
  assign last_word = ((cnt_q + 16'd1) == len_q);

`ifdef PROG_LOADER_CSUM_EN
  loader_checksum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .add  (xfer),
    .din  (bus.rx_data),
    .zero (csum_zero)
  );
`else
  assign csum_zero = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN_LO;
      S_LEN_LO: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_d = len_bad ? S_ERR : S_W_LO;
      end
      S_W_LO: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_d = S_W_HI;
      end
      S_W_HI: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_d = (bus.rx_data[7:6] != 2'b00) ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
`ifdef PROG_LOADER_CSUM_EN
        state_d = last_word ? S_CSUM : S_W_LO;
`else
        state_d = last_word ? S_DONE : S_W_LO;
`endif
      end
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM: begin
        rdy = 1'b1;
        if (bus.rx_valid) state_d = csum_zero ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE) && (state_q != S_DONE);
      if (start_ok) begin
        cnt_q  <= '0;
        addr_q <= '0;
      end
      if (xfer && state_q == S_LEN_LO) len_q[7:0]  <= bus.rx_data;
      if (xfer && state_q == S_LEN_HI) len_q[15:8] <= bus.rx_data;
      if (xfer && state_q == S_W_LO)   lo_q        <= bus.rx_data;
      if (xfer && state_q == S_W_HI)   wdata_q     <= {bus.rx_data[5:0], lo_q};
      // address wraps after 2047; the length limit keeps that from aliasing
      if (state_q == S_WRITE) begin
        cnt_q  <= cnt_q + 16'd1;
        addr_q <= addr_q + PM_ADDR_W'(1);
      end
    end
  end

  assign bus.rx_ready = rdy;
  assign bus.pm_we    = (state_q == S_WRITE);
  assign bus.pm_addr  = addr_q;
  assign bus.pm_wdata = wdata_q;
  assign done         = done_q;
  assign error        = (state_q == S_ERR);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign cpu_hold     = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule
